dec_pipe_n: RTL

//  Parametrised, pipelined code-to-vector decoder; successor to the fixed 3-to-8 / 7-to-128 decoders.

---
 rtl/dec_pkg.sv | 16 +
 rtl/dec_core.sv | 37 +++
 rtl/dec_pipe_n.sv | 108 ++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared types for the pipelined code-to-vector decoder.
// Holds the decode mode encodings and the request bundle used by the skid entry.
package dec_pkg;

   localparam logic MODE_ONEHOT = 1'b0;
   localparam logic MODE_THERMO = 1'b1;

   // Widest code any instance may carry.
   localparam int CODE_W_MAX = 16;

   typedef struct packed {
      logic [CODE_W_MAX-1:0] code;
      logic                  mode;
   } dec_req_t;

endpackage

// File: rtl/dec_core.sv
// Combinational decode of (code, mode) into a one-hot or thermometer vector.
// Ports: code/mode in; vec (OUT_N bits) and err (code >= OUT_N) out.
module dec_core
   import dec_pkg::*;
#(
   parameter int IN_W  = 7,
   parameter int OUT_N = 128
) (
   input  logic [IN_W-1:0]  code,
   input  logic             mode,
   output logic [OUT_N-1:0] vec,
   output logic             err
);

   // One extra bit so OUT_N = 2**IN_W is representable.
   localparam logic [IN_W:0] LIMIT = (IN_W+1)'(OUT_N);

   logic [IN_W:0] c;
   assign c = {1'b0, code};

   always_comb begin
      err = (c >= LIMIT);
      vec = '0;
      for (int i = 0; i < OUT_N; i++) begin
         unique case (1'b1)
            (mode == MODE_THERMO):
               vec[i] = ((IN_W+1)'(i) <= c);
            default:
               vec[i] = (c == (IN_W+1)'(i));
         endcase
      end
      if (err) begin
         vec = (mode == MODE_THERMO) ? '1 : '0;
      end
   end

endmodule

// File: rtl/dec_pipe_n.sv
// Pipelined code-to-vector decoder with a 1-entry skid and an error counter.
// Ports: clk, rst, in_valid/in_ready/in_code/in_mode, out_valid/out_ready/out_vec/out_err, err_cnt, clr_err.
module dec_pipe_n
   import dec_pkg::*;
#(
   parameter int IN_W     = 7,
   parameter int OUT_N    = 128,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_W-1:0]     in_code,
   input  logic                in_mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_N-1:0]    out_vec,
   output logic                out_err,
   output logic [ERRCNT_W-1:0] err_cnt,
   input  logic                clr_err
);

   if (OUT_N < 1 || OUT_N > (1 << IN_W)) begin : g_bad_n
      $error("dec_pipe_n: OUT_N must be in 1..2**IN_W");
   end
   if (IN_W < 1 || IN_W > CODE_W_MAX) begin : g_bad_w
      $error("dec_pipe_n: IN_W must be in 1..CODE_W_MAX");
   end

   localparam logic [ERRCNT_W-1:0] CNT_MAX = '1;

   dec_req_t         in_req;
   dec_req_t         skid;
   dec_req_t         src;
   logic             skid_v;
   logic             in_fire;
   logic             out_fire;
   logic             out_free;
   logic             load_out;
   logic             skid_wr;
   logic             ov_n;
   logic             skid_v_n;
   logic [OUT_N-1:0] core_vec;
   logic             core_err;

   always_comb begin
      in_req      = '0;
      in_req.code = CODE_W_MAX'(in_code);
      in_req.mode = in_mode;
   end

   // Flop output, so in_ready is registered.
   assign in_ready = ~skid_v;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign out_free = ~out_valid | out_ready;

   // Skid is older than any new request, so it loads first.
   assign src      = skid_v ? skid : in_req;
   assign load_out = out_free & (skid_v | in_fire);
   assign skid_wr  = in_fire & ~out_free;
   assign ov_n     = out_free ? (skid_v | in_fire) : 1'b1;
   assign skid_v_n = skid_wr | (skid_v & ~out_free);

   dec_core #(
      .IN_W  (IN_W),
      .OUT_N (OUT_N)
   ) u_core (
      .code (src.code[IN_W-1:0]),
      .mode (src.mode),
      .vec  (core_vec),
      .err  (core_err)
   );

   if (IN_W < CODE_W_MAX) begin : g_hi
      logic unused_hi;
      assign unused_hi = |src.code[CODE_W_MAX-1:IN_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_vec   <= '0;
         out_err   <= 1'b0;
         skid_v    <= 1'b0;
         skid      <= '0;
         err_cnt   <= '0;
      end else begin
         out_valid <= ov_n;
         skid_v    <= skid_v_n;
         if (load_out) begin
            out_vec <= core_vec;
            out_err <= core_err;
         end
         if (skid_wr) begin
            skid <= in_req;
         end
         if (clr_err) begin
            err_cnt <= '0;
         end else if (out_fire && out_err && err_cnt != CNT_MAX) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

endmodule
